// File: rtl/led_chaser.sv
// Parametrised LED pattern sequencer: rotate left/right, ping-pong and bar fill with a programmable step rate.
// Optional fading trail on the previous position when LED_TRAIL_EN is defined.

module led_cell #(
  parameter int POS_W = 3,
  parameter int IDX   = 0
) (
  input  logic [POS_W-1:0] pos,
  input  logic             bar,
  input  logic             trail_on,
  input  logic [POS_W-1:0] trail_pos,
  output logic             lit
);
  localparam logic [POS_W-1:0] ID = POS_W'(IDX);

  always_comb begin
    lit = 1'b0;
    if (bar) lit = (ID <= pos);
    else     lit = (pos == ID) || (trail_on && (trail_pos == ID));
  end
endmodule

module led_chaser #(
  parameter int N_LED       = 8,
  parameter int STEP_CYCLES = 10_000_000,
  parameter int CNT_W       = 30,
  parameter int POS_W       = 3
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             step_pulse,
  output logic [POS_W-1:0] pos
);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [CNT_W-1:0] cnt, limit_m1;
  logic             step;
  dir_t             dir, dir_nxt, dir_eff;
  logic [1:0]       mode_q, mode_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic [N_LED-1:0] led_nxt;

  // >= rather than == so a speed-up mid-count steps next cycle instead of wrapping
  assign limit_m1 = CNT_W'((STEP_CYCLES >> speed) - 1);
  assign step     = en && (cnt >= limit_m1);

  always_comb begin
    pos_nxt  = pos;
    dir_nxt  = dir;
    mode_nxt = mode_q;
    dir_eff  = dir;
    if (step) begin
      mode_nxt = mode;
      case (mode)
        2'd1: pos_nxt = (pos == '0) ? LAST : pos - ONE;
        2'd2: begin
          if (mode_q != 2'd2) dir_eff = (pos == LAST) ? DOWN : UP;
          if (dir_eff == UP) begin
            if (pos == LAST) begin dir_nxt = DOWN; pos_nxt = LAST - ONE; end
            else             begin dir_nxt = UP;   pos_nxt = pos + ONE;  end
          end else begin
            if (pos == '0)   begin dir_nxt = UP;   pos_nxt = ONE;        end
            else             begin dir_nxt = DOWN; pos_nxt = pos - ONE;  end
          end
        end
        default: pos_nxt = (pos == LAST) ? '0 : pos + ONE;
      endcase
    end
  end

`ifdef LED_TRAIL_EN
  logic [7:0]       pwm_cnt, pwm_nxt;
  logic [POS_W-1:0] prev_pos, prev_nxt;
  logic             trail_on;

  assign pwm_nxt  = pwm_cnt + 8'd1;
  assign prev_nxt = step ? pos : prev_pos;
  assign trail_on = (pwm_nxt[7:6] == 2'b00) && (prev_nxt != pos_nxt) && (mode_nxt != 2'd3);

  always_ff @(posedge clk50m) begin
    if (rst) begin
      pwm_cnt  <= '0;
      prev_pos <= '0;
    end else begin
      pwm_cnt  <= pwm_nxt;
      prev_pos <= prev_nxt;
    end
  end
`else
  logic             trail_on;
  logic [POS_W-1:0] prev_nxt;
  assign trail_on = 1'b0;
  assign prev_nxt = '0;
`endif

  // led is registered from the next-state decode so it moves on the same edge as pos
  for (genvar i = 0; i < N_LED; i++) begin : g_cell
    led_cell #(.POS_W(POS_W), .IDX(i)) u_cell (
      .pos       (pos_nxt),
      .bar       (mode_nxt == 2'd3),
      .trail_on  (trail_on),
      .trail_pos (prev_nxt),
      .lit       (led_nxt[i])
    );
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt        <= '0;
      pos        <= '0;
      dir        <= UP;
      mode_q     <= 2'd0;
      step_pulse <= 1'b0;
      led        <= N_LED'(1);
    end else begin
      step_pulse <= step;
      if (en) cnt <= step ? '0 : cnt + CNT_W'(1);
      pos    <= pos_nxt;
      dir    <= dir_nxt;
      mode_q <= mode_nxt;
      led    <= led_nxt;
    end
  end
endmodule

// File: tb/tb_led_chaser.sv
// Randomised bench for led_chaser: a reference model pushes the expected outputs per edge; a monitor pops and compares.
module tb_led_chaser;
  localparam int N  = 8;
  localparam int SC = 8;
  localparam int CW = 4;
  localparam int PW = 3;

  logic          clk50m = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    speed = 2'd0;
  logic [N-1:0]  led;
  logic          step_pulse;
  logic [PW-1:0] pos;

  led_chaser #(.N_LED(N), .STEP_CYCLES(SC), .CNT_W(CW), .POS_W(PW)) dut (
    .clk50m     (clk50m),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .speed      (speed),
    .led        (led),
    .step_pulse (step_pulse),
    .pos        (pos)
  );

  always #5 clk50m = ~clk50m;

  typedef struct {
    longint led;
    int     pos;
    bit     sp;
    int     cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, passed = 0, fails = 0, cyc = 0;
  bit   done = 1'b0;

  // Reference model: elapsed-cycle counter, position arithmetic modulo N,
  // ping-pong as a phase around a 2N-2 step circle.
  int m_cnt = 0, m_pos = 0, m_mq = 0, m_ph = 0, m_prev = 0, m_pwm = 0;

  always @(posedge clk50m) begin
    exp_t e;
    bit   stp;
    stp = 1'b0;
    cyc++;
    if (rst) begin
      m_cnt = 0; m_pos = 0; m_mq = 0; m_ph = 0; m_prev = 0; m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 256;
      if (en) begin
        if (m_cnt >= (SC >> speed) - 1) begin m_cnt = 0; stp = 1'b1; end
        else m_cnt++;
      end
      if (stp) begin
        m_prev = m_pos;
        if (mode == 2'd2) begin
          if (m_mq != 2) m_ph = (m_pos == N-1) ? N-1 : m_pos;
          m_ph  = (m_ph + 1) % (2*N - 2);
          m_pos = (m_ph < N) ? m_ph : 2*N - 2 - m_ph;
        end else if (mode == 2'd1) m_pos = (m_pos + N - 1) % N;
        else                       m_pos = (m_pos + 1) % N;
        m_mq = int'(mode);
      end
    end
    e.sp  = stp;
    e.pos = m_pos;
    e.cyc = cyc;
    e.led = (m_mq == 3) ? ((64'd1 << (m_pos + 1)) - 64'd1) : (64'd1 << m_pos);
`ifdef LED_TRAIL_EN
    if (m_mq != 3 && m_prev != m_pos && m_pwm < 64) e.led = e.led | (64'd1 << m_prev);
`endif
    sbq.push_back(e);
  end

  always @(negedge clk50m) begin
    exp_t e;
    if (!done) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow: no expected entry at time %0t (need one per edge)", $time);
      end else begin
        e = sbq.pop_front();
        if (led === N'(e.led) && pos === PW'(e.pos) && step_pulse === e.sp) passed++;
        else begin
          fails++;
          if (fails <= 20)
            $display("FAIL out cyc%0d: led=%h pos=%0d step=%b, expected led=%h pos=%0d step=%b",
                     e.cyc, led, pos, step_pulse, N'(e.led), e.pos, e.sp);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk50m);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; speed = 2'd0;
    run(3);
    rst = 1'b0; en = 1'b1;
    run(8 * 9);
    // ping-pong over more than a full period at double speed
    mode = 2'd2; speed = 2'd1;
    run(4 * 16);
    mode = 2'd3;
    run(4 * 9);
    mode = 2'd1;
    run(4 * 4);
    // fast stepping, then a freeze and resume
    speed = 2'd2;
    run(20);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(10);
    // mid-count mode and speed changes
    speed = 2'd0; mode = 2'd0;
    run(3);
    mode = 2'd1;
    run(10);
    run(3);
    speed = 2'd3;
    run(4);
    speed = 2'd0;
    run(5);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(12);
    // back-to-back steps across every mode transition
    speed = 2'd3;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      run(9);
    end
    for (int i = 0; i < 600; i++) begin
      en = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) mode  = 2'($urandom % 4);
      if ($urandom % 32 == 0) speed = 2'($urandom % 4);
      rst = ($urandom % 64) == 0;
      run(1);
    end
    rst = 1'b0;
    run(2);
    @(posedge clk50m);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
